// File: rtl/pipe_pkg.sv
// Shared types and defaults for the elastic pipeline skid buffer.
// Pulled in by the buffer top and by anything that needs its state encoding.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_t;

   localparam int PIPE_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit payload register with load enable and synchronous active-low clear.
// Zero latency: the new value is visible after the loading edge; clear beats load.
module pipe_data_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             i_clr_n,
   input  logic             i_ld,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (!i_clr_n) begin
         r_q <= '0;
      end else if (i_ld) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic stage: accepted word shows on out_* after one edge; full throughput.
// in_ready is a flop (low only while skid holds a word), so downstream stalls never reach upstream combinationally.
module pipe_skid_buffer
   import pipe_pkg::*;
#(
   parameter int WIDTH = PIPE_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   skid_state_t      r_state;
   skid_state_t      w_state_nxt;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic             w_main_ld;
   logic             w_main_from_skid;
   logic             w_skid_ld;
   logic [WIDTH-1:0] w_main_d;
   logic [WIDTH-1:0] w_main_q;
   logic [WIDTH-1:0] w_skid_q;

   assign w_in_xfer  = in_valid && r_in_ready;
   assign w_out_xfer = r_out_valid && out_ready;

   always_comb begin
      w_state_nxt      = r_state;
      w_main_ld        = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_ld        = 1'b0;
      if (flush) begin
         // Flush drops everything, including a word handshaked on this same edge.
         w_state_nxt = EMPTY;
      end else begin
         unique case (r_state)
            EMPTY: begin
               if (w_in_xfer) begin
                  w_main_ld   = 1'b1;
                  w_state_nxt = ONE;
               end
            end
            ONE: begin
               if (w_in_xfer && w_out_xfer) begin
                  w_main_ld = 1'b1;
               end else if (w_in_xfer) begin
                  w_skid_ld   = 1'b1;
                  w_state_nxt = TWO;
               end else if (w_out_xfer) begin
                  w_state_nxt = EMPTY;
               end
            end
            TWO: begin
               if (w_out_xfer) begin
                  w_main_ld        = 1'b1;
                  w_main_from_skid = 1'b1;
                  w_state_nxt      = ONE;
               end
            end
            default: begin
               w_state_nxt = EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt != TWO);
         r_out_valid <= (w_state_nxt != EMPTY);
      end
   end

   assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

   pipe_data_reg #(.WIDTH(WIDTH)) u_main (
      .clk     (clk),
      .i_clr_n (reset),
      .i_ld    (w_main_ld),
      .i_d     (w_main_d),
      .o_q     (w_main_q)
   );

   pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
      .clk     (clk),
      .i_clr_n (reset),
      .i_ld    (w_skid_ld),
      .i_d     (in_data),
      .o_q     (w_skid_q)
   );

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = w_main_q;

endmodule

// File: doc/pipe_skid_buffer.md
# pipe_skid_buffer

Elastic pipeline register that sits between two processor pipeline stages and gives downstream back-pressure a registered path upstream. Our plain stage registers capture unconditionally every cycle; this block captures only on a valid/ready handshake. It holds up to two words (main plus skid), so a stall never drops data and never needs a combinational ready path. It also supports a stage flush for branch mispredicts.

## Interface
- WIDTH, 32, payload width in bits (WIDTH >= 1)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (sampled on posedge clk)
- flush  input  1  synchronous kill of all held words, active-high
- in_valid  input  1  upstream word present
- in_ready  output  1  block can accept a word this cycle; driven directly from a flop
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  word presented downstream
- out_ready  input  1  downstream accepts this cycle
- out_data  output  WIDTH  downstream payload, driven directly from the main register

## Operation
- Transfer in: in_valid && in_ready at a posedge. Transfer out: out_valid && out_ready at a posedge.
- Storage: main (data + valid) drives the outputs. Skid (data + valid) holds overflow.
- in_ready = !skid_valid, registered.
- FSM states: EMPTY (neither valid), ONE (main valid only), TWO (both valid).
- EMPTY: in-transfer -> main <= in_data, go ONE.
- ONE, in-transfer only -> skid <= in_data, go TWO.
- ONE, out-transfer only -> go EMPTY.
- ONE, both transfers -> main <= in_data, stay ONE.
- ONE, neither -> hold.
- TWO: in_ready=0, so no in-transfer is possible.
- TWO, out-transfer -> main <= skid, skid cleared, go ONE.
- TWO, no out-transfer -> hold.
- Ordering is strict FIFO; no word is ever duplicated or dropped.
- flush=1 -> go EMPTY next cycle, in_ready=1. flush has priority over any simultaneous in- or out-transfer, and the in-transfer word is discarded. Data registers may keep stale contents.
- reset=0 -> same as flush, and out_data and the skid data are also cleared to 0. reset has priority over flush.
- While out_valid=1 and out_ready=0, out_data and out_valid are stable.

## Timing
- Reset values: out_valid=0, out_data=0, in_ready=1, state EMPTY.
- Latency: a word accepted at edge N appears on out_valid/out_data after edge N (in EMPTY, or ONE with simultaneous out-transfer).
- Throughput: one word per cycle sustained while out_ready=1.
- in_ready falls the cycle after entering TWO. It rises the cycle after the first out-transfer from TWO.
- There is no combinational path from out_ready or in_valid to any output.
- Reset or flush asserted mid-stall (state TWO): both words are lost, and out_valid=0 after that edge.
- Upstream obligation: in_valid/in_data are held until accepted. Downstream may toggle out_ready freely.

## Structure
- Shared package pipe_pkg:
  - typedef enum logic [1:0] skid_state_t {EMPTY, ONE, TWO}
  - localparam PIPE_WIDTH_DEFAULT = 32
- Sub-module pipe_data_reg (WIDTH-bit register with load enable and synchronous active-low clear), instantiated twice: main and skid.
- The FSM and valid/ready flops live in the top module.

## Test plan
- Reset: reset=0 for 2 cycles with in_valid=1, in_data=0xDEADBEEF -> out_valid=0, out_data=0, in_ready=1 throughout and one cycle after release.
- Streaming: out_ready=1, push 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on the following consecutive cycles, in_ready stays 1.
- Stall/skid: push 0xA then 0xB with out_ready=0 -> in_ready=0 after the second edge, out_data holds 0xA. Raise out_ready -> 0xA then 0xB delivered, in_ready=1 one cycle after 0xA leaves.
- Flush priority: state TWO (0xA,0xB), assert flush with out_ready=1 and in_valid=1 (0xC) -> next cycle out_valid=0, in_ready=1, and none of 0xA/0xB/0xC is ever output.
- Simultaneous in/out in ONE: hold 0x5, push 0x6 with out_ready=1 -> 0x5 consumed, out_data=0x6 next cycle, state ONE.
- Random back-pressure: 1000 random words with random in_valid/out_ready -> scoreboard shows identical in-order sequence and out_data never changes while out_valid && !out_ready.
